// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/VALID/HALTED sequencer with one outstanding icache request.
// Define FETCH_OVERLAP_EN to let a consumed instruction overlap the next fetch (1 instr/cycle peak).
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_update,
  input  logic [1:0]  PCSel,
  input  logic        branch_taken,
  input  logic [25:0] jaddr,
  input  logic [31:0] imm,
  input  logic [31:0] jr_target,
  input  logic [31:0] base_npc,
  input  logic        halt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    VALID  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        overlap_load;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = pc_update && (PCSel != 2'b11);
  assign imemaddr = pc;
  assign instr_valid = (state == VALID);

  always_comb begin
    target = base_npc;
    unique case (PCSel)
      2'b00:   target = {base_npc[31:28], jaddr, 2'b00};
      2'b01:   target = branch_taken ? (base_npc + {imm[29:0], 2'b00}) : base_npc;
      2'b10:   target = jr_target;
      default: target = base_npc;
    endcase
  end

  // In overlap mode the request in VALID is issued only when decode is taking the current instr.
`ifdef FETCH_OVERLAP_EN
  assign overlap_load = instr_ready && ihit;
  always_comb begin
    iREN = (state == FETCH) || ((state == VALID) && instr_ready);
  end
`else
  assign overlap_load = 1'b0;
  always_comb begin
    iREN = (state == FETCH);
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
      pc    <= PC_INIT;
      instr <= 32'h0;
      npc   <= 32'h0;
    end else begin
      unique case (state)
        HALTED: begin
          state <= HALTED;
        end
        FETCH: begin
          if (halt) begin
            state <= HALTED;
          end else if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (ihit) begin
            instr <= imemload;
            npc   <= pc_plus4;
            pc    <= pc_plus4;
            state <= VALID;
          end
        end
        VALID: begin
          if (halt) begin
            state <= HALTED;
          end else if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (instr_ready) begin
            if (overlap_load) begin
              instr <= imemload;
              npc   <= pc_plus4;
              pc    <= pc_plus4;
              state <= VALID;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: redirect vector table, hand-written corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_fetch_unit;

`ifdef FETCH_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam logic [31:0] PCI = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_update;
  logic [1:0]  PCSel;
  logic        branch_taken;
  logic [25:0] jaddr;
  logic [31:0] imm;
  logic [31:0] jr_target;
  logic [31:0] base_npc;
  logic        halt;

  int checks = 0;
  int failures = 0;

  // Reference model state: what the decode side should currently observe.
  logic [31:0] m_pc, m_instr, m_npc;
  bit          m_valid, m_halted;

  fetch_unit #(.PC_INIT(PCI)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .imemaddr(imemaddr), .instr(instr), .npc(npc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_update(pc_update), .PCSel(PCSel),
    .branch_taken(branch_taken), .jaddr(jaddr), .imm(imm), .jr_target(jr_target),
    .base_npc(base_npc), .halt(halt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sel;
    logic        bt;
    logic [25:0] ja;
    logic [31:0] im;
    logic [31:0] jt;
    logic [31:0] bn;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs [8];
  logic [31:0] exp_a [6];
  logic        exp_v [6];
  logic [31:0] got_a [6];
  logic        got_v [6];
  int          halted_cycles;
  logic [31:0] frozen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic pu, input logic [1:0] sel, input logic bt,
                               input logic [25:0] ja, input logic [31:0] im, input logic [31:0] jt,
                               input logic [31:0] bn, input logic hl, input logic hit,
                               input logic [31:0] load, input logic rdy);
    pc_update = pu; PCSel = sel; branch_taken = bt; jaddr = ja; imm = im;
    jr_target = jt; base_npc = bn; halt = hl; ihit = hit; imemload = load; instr_ready = rdy;
  endtask

  task automatic idle(input logic hit, input logic [31:0] load, input logic rdy);
    applyStimulus(1'b0, 2'b11, 1'b0, 26'h0, 32'h0, 32'h0, 32'h0, 1'b0, hit, load, rdy);
  endtask

  function automatic logic [31:0] modelTarget();
    logic [31:0] t;
    case (PCSel)
      2'd0:    t = (base_npc & 32'hF000_0000) | (32'(jaddr) * 32'd4);
      2'd1:    t = branch_taken ? base_npc + imm * 32'd4 : base_npc;
      default: t = jr_target;
    endcase
    return t;
  endfunction

  function automatic bit expIren();
    return !m_halted && (!m_valid || (OVL && instr_ready));
  endfunction

  task automatic modelReset();
    m_pc = PCI; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic modelLoad();
    m_instr = imemload;
    m_npc   = m_pc + 32'd4;
    m_pc    = m_pc + 32'd4;
    m_valid = 1'b1;
  endtask

  task automatic modelUpdate();
    if (m_halted) return;
    if (halt) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (pc_update && PCSel != 2'b11) begin
      m_pc    = modelTarget();
      m_valid = 1'b0;
    end else if (!m_valid) begin
      if (ihit) modelLoad();
    end else if (instr_ready) begin
      if (OVL && ihit) modelLoad();
      else m_valid = 1'b0;
    end
  endtask

  task automatic checkModel();
    checkOutput("imemaddr", imemaddr, m_pc);
    checkOutput("iREN", {31'b0, iREN}, {31'b0, expIren()});
    checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    if (m_valid) begin
      checkOutput("instr", instr, m_instr);
      checkOutput("npc", npc, m_npc);
    end
  endtask

  // Inputs are set just after a falling edge; outputs are checked before the rising edge.
  task automatic stepCycle();
    #1 checkModel();
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);
  endtask

  task automatic doReset();
    nRST = 1'b0;
    idle(1'b0, 32'h0, 1'b0);
    modelReset();
    #1;
    checkOutput("reset imemaddr", imemaddr, PCI);
    checkOutput("reset instr_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("reset instr", instr, 32'h0);
    checkOutput("reset npc", npc, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    vecs[0] = '{2'b01, 1'b1, 26'h0, 32'hFFFF_FFFE, 32'h0, 32'h10, 32'h8};
    vecs[1] = '{2'b01, 1'b0, 26'h0, 32'hFFFF_FFFE, 32'h0, 32'h10, 32'h10};
    vecs[2] = '{2'b00, 1'b0, 26'h100, 32'h0, 32'h0, 32'h8000_0004, 32'h8000_0400};
    vecs[3] = '{2'b10, 1'b0, 26'h0, 32'h0, 32'h44, 32'h0, 32'h44};
    vecs[4] = '{2'b11, 1'b1, 26'h123, 32'h4, 32'h44, 32'h99, PCI};
    vecs[5] = '{2'b01, 1'b1, 26'h0, 32'h2, 32'h0, 32'hFFFF_FFFC, 32'h4};
    vecs[6] = '{2'b00, 1'b0, 26'h3FF_FFFF, 32'h0, 32'h0, 32'h7000_0000, 32'h7FFF_FFFC};
    vecs[7] = '{2'b10, 1'b0, 26'h0, 32'h0, 32'h3, 32'h0, 32'h3};
    if (OVL) begin
      exp_a = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
      exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    end else begin
      exp_a = '{32'd0, 32'd4, 32'd4, 32'd8, 32'd8, 32'd12};
      exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    end

    @(negedge CLK);
    doReset();

    // Redirect target table, each from a fresh FETCH at PC_INIT.
    for (int i = 0; i < 8; i++) begin
      doReset();
      applyStimulus(1'b1, vecs[i].sel, vecs[i].bt, vecs[i].ja, vecs[i].im, vecs[i].jt,
                    vecs[i].bn, 1'b0, 1'b0, 32'h0, 1'b0);
      stepCycle();
      idle(1'b0, 32'h0, 1'b0);
      #1 checkOutput($sformatf("redirect vec%0d imemaddr", i), imemaddr, vecs[i].exp_addr);
      checkOutput($sformatf("redirect vec%0d instr_valid", i), {31'b0, instr_valid}, 32'h0);
    end

    // Streaming with ihit and instr_ready held high.
    doReset();
    for (int k = 0; k < 6; k++) begin
      idle(1'b1, 32'hA000_0000 + 32'(k), 1'b1);
      #1 got_a[k] = imemaddr;
      got_v[k] = instr_valid;
      stepCycle();
    end
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("stream addr%0d", k), got_a[k], exp_a[k]);
      checkOutput($sformatf("stream valid%0d", k), {31'b0, got_v[k]}, {31'b0, exp_v[k]});
    end

    // Decode stall: instr/npc held, no new request.
    doReset();
    idle(1'b1, 32'h2001_0005, 1'b0);
    stepCycle();
    idle(1'b0, 32'hFFFF_FFFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1 checkOutput("stall instr", instr, 32'h2001_0005);
      checkOutput("stall npc", npc, 32'h4);
      checkOutput("stall iREN", {31'b0, iREN}, 32'h0);
      checkOutput("stall valid", {31'b0, instr_valid}, 32'h1);
      stepCycle();
    end
    idle(1'b0, 32'h0, 1'b1);
    stepCycle();

    // jr redirect with concurrent ihit: fetched data must be dropped.
    doReset();
    applyStimulus(1'b1, 2'b10, 1'b0, 26'h0, 32'h0, 32'h44, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    stepCycle();
    idle(1'b1, 32'h0000_1234, 1'b0);
    #1 checkOutput("jr imemaddr", imemaddr, 32'h44);
    checkOutput("jr valid", {31'b0, instr_valid}, 32'h0);
    stepCycle();
    #1 checkOutput("jr instr", instr, 32'h0000_1234);
    checkOutput("jr npc", npc, 32'h48);
    stepCycle();

    // pc+4 wraps at the top of the address space.
    doReset();
    applyStimulus(1'b1, 2'b10, 1'b0, 26'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    stepCycle();
    idle(1'b1, 32'h0000_0055, 1'b0);
    stepCycle();
    #1 checkOutput("wrap npc", npc, 32'h0);
    checkOutput("wrap imemaddr", imemaddr, 32'h0);
    stepCycle();

    // Halt wins over a concurrent redirect, then stays frozen.
    doReset();
    idle(1'b1, 32'h0000_0011, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 2'b00, 1'b0, 26'h100, 32'h0, 32'h0, 32'h8000_0004, 1'b1, 1'b0, 32'h0, 1'b0);
    stepCycle();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'($urandom_range(1)), 2'($urandom_range(3)), 1'b1, 26'($urandom),
                    $urandom, $urandom, $urandom, 1'($urandom_range(1)), 1'b0, $urandom,
                    1'($urandom_range(1)));
      #1 checkOutput("halted iREN", {31'b0, iREN}, 32'h0);
      checkOutput("halted imemaddr", imemaddr, 32'h4);
      checkOutput("halted valid", {31'b0, instr_valid}, 32'h0);
      stepCycle();
    end

    // Asynchronous reset pulse mid-stream, asserted between clock edges.
    doReset();
    for (int k = 0; k < 3; k++) begin
      idle(1'b1, 32'hC000_0000 + 32'(k), 1'b1);
      stepCycle();
    end
    #2 nRST = 1'b0;
    #1 checkOutput("async rst imemaddr", imemaddr, PCI);
    checkOutput("async rst valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("async rst npc", npc, 32'h0);
    modelReset();
    idle(1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;

    // Randomized traffic against the model.
    doReset();
    halted_cycles = 0;
    for (int n = 0; n < 4000; n++) begin
      instr_ready = ($urandom_range(99) < 60);
      pc_update = ($urandom_range(99) < 15);
      PCSel = 2'($urandom_range(3));
      branch_taken = 1'($urandom_range(1));
      jaddr = 26'($urandom);
      imm = ($urandom_range(1) == 1) ? 32'($signed($urandom_range(64)) - 32) : $urandom;
      jr_target = $urandom;
      base_npc = $urandom;
      halt = ($urandom_range(399) == 0);
      imemload = $urandom;
      ihit = expIren() && ($urandom_range(1) == 1);
      stepCycle();
      if (m_halted) halted_cycles++;
      if (halted_cycles > 15 || $urandom_range(499) == 0) begin
        halted_cycles = 0;
        doReset();
      end
    end

    frozen = m_pc;
    $display("[TB] random phase done, last model pc %h", frozen);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: PC_INIT, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have ports:
- CLK  in  1  single clock, all state rising-edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache: imemload valid this cycle.
- imemload  in  32  icache read data.
- iREN  out  1  icache read request.
- imemaddr  out  32  icache address (= pc).
- instr  out  32  instruction to control unit.
- npc  out  32  address of instr + 4.
- instr_valid  out  1  instr/npc valid.
- instr_ready  in  1  decode consumes instr this cycle.
- pc_update  in  1  resolving-stage strobe, redirect info valid.
- PCSel  in  2  00 jump, 01 branch, 10 jr, 11 sequential.
- branch_taken  in  1  branch condition met (PCSel=01).
- jaddr  in  26  J/JAL target field.
- imm  in  32  sign-extended branch offset.
- jr_target  in  32  register value for jr.
- base_npc  in  32  npc of resolving instruction.
- halt  in  1  HALT decoded.

Function
REQ-003 SHALL implement states FETCH, VALID, HALTED; at most one icache request outstanding.
REQ-004 FETCH: iREN=1, imemaddr=pc, instr_valid=0; on ihit and no redirect: instr<=imemload, npc<=pc+4, pc<=pc+4, go VALID.
REQ-005 VALID: instr_valid=1; instr/npc held stable until instr_ready=1; on instr_ready go FETCH (no overlap, see REQ-014).
REQ-006 Redirect = pc_update with PCSel!=11; target: 00 {base_npc[31:28], jaddr, 2'b00}; 01 taken base_npc+(imm<<2) mod 2^32, not taken base_npc; 10 jr_target.
REQ-007 Redirect in any non-HALTED state SHALL set pc<=target next edge, clear instr_valid, enter FETCH; same-cycle ihit data discarded.
REQ-008 pc_update with PCSel=11 SHALL have no effect.
REQ-009 Redirect and halt same cycle: halt wins.
REQ-010 halt=1 SHALL enter HALTED next edge; HALTED: iREN=0, instr_valid=0, pc frozen; exit only via nRST.
REQ-011 pc+4 and branch target SHALL wrap modulo 2^32; no alignment checks.
REQ-012 imemaddr SHALL equal pc in all states; iREN SHALL be 0 in HALTED.

Reset
REQ-013 nRST=0 SHALL asynchronously set pc=PC_INIT, state=FETCH, instr=0, npc=0, instr_valid=0; iREN=1 from the first edge after release; a request pending at reset is abandoned.

Configuration
REQ-014 Macro FETCH_OVERLAP_EN: defined -> in VALID with instr_ready=1, iREN=1 (combinational from instr_ready), and ihit loads next instr/npc, stays VALID (1 instr/cycle peak); ihit without instr_ready cannot occur as iREN=0. Undefined -> VALID always returns to FETCH, minimum 2 cycles/instr.

Verification
REQ-015 Reset, PC_INIT=0, ihit=1 constant, instr_ready=1 -> imemaddr 0,4,8 sequence; instr_valid every 2nd cycle (every cycle with FETCH_OVERLAP_EN).
REQ-016 instr_ready=0 for 5 cycles after instr 0x2001_0005 at pc 0 -> instr/npc held at 0x2001_0005/0x4, iREN=0 throughout.
REQ-017 pc_update, PCSel=01, taken, base_npc=0x10, imm=0xFFFF_FFFE -> next imemaddr 0x8; not taken -> 0x10.
REQ-018 PCSel=00, base_npc=0x8000_0004, jaddr=0x100 -> imemaddr 0x8000_0400; PCSel=10, jr_target=0x44 with concurrent ihit -> ihit data dropped, imemaddr 0x44.
REQ-019 halt with concurrent redirect -> HALTED, iREN=0, pc frozen 10 cycles; nRST pulse mid-operation -> pc=PC_INIT, instr_valid=0 immediately.
